clk_edge_meter: RTL and testbench

Measures an incoming divided or externally generated slow clock from inside the `clk_in` domain. It produces single-cycle rise and fall strobes, the measured half-period and full period in `clk_in` cycles, a lock indication, and a timeout flag. It is the consuming end of the divided-clock path: it is used to verify divider outputs and codec bit/word clocks before the audio front end trusts them.

---
 rtl/clk_meter_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 59 +++++
 rtl/clk_edge_meter.sv | 217 +++++++++++++++++++++
 tb/tb_clk_edge_meter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the slow-clock edge meter.
// Optional duty check in clk_edge_meter is enabled by CLK_EDGE_METER_DUTY_CHECK_EN.
package clk_meter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2
    } lock_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous slow clock, with registered rise/fall strobes.
// The *_det_o outputs lead the strobes by one cycle so the owner can register results alongside them.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_det_o,
    output logic fall_det_o,
    output logic rise_pulse_o,
    output logic fall_pulse_o
);

    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic                   armed;
    logic                   sync_out;
    logic                   rise_q;
    logic                   fall_q;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign sync_out = sync_q[SYNC_STAGES-1];

    // Held off until the chain and prev have both seen the live input, so a
    // level that was already high at reset release is not reported as a rise.
    assign armed      = (arm_cnt_q == ARM_W'(ARM_CYCLES));
    assign rise_det_o = armed &  sync_out & ~prev_q;
    assign fall_det_o = armed & ~sync_out &  prev_q;

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments let every flop sample the pre-edge
        // value of its neighbour, which is what makes the chain a shift register.
        if (rst_i) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_out;
            if (!armed) begin
                arm_cnt_q <= arm_cnt_q + ARM_W'(1);
            end
            rise_q <= rise_det_o;
            fall_q <= fall_det_o;
        end
    end

    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;

endmodule

// File: rtl/clk_edge_meter.sv
// Measures half-period, period, lock and timeout of a slow clock seen from clk_in.
// Define CLK_EDGE_METER_DUTY_CHECK_EN to build the high/low balance check behind duty_err.
module clk_edge_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT     = 1_000_000,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic             duty_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LOCK_TOL_C = CNT_W'(LOCK_TOL);
    localparam int unsigned      MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_COUNT_C = MATCH_W'(LOCK_COUNT);

    function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic rise_det;
    logic fall_det;
    logic any_edge;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i        (clk_in),
        .rst_i        (rst),
        .sig_i        (div_clk_in),
        .rise_det_o   (rise_det),
        .fall_det_o   (fall_det),
        .rise_pulse_o (rise_pulse),
        .fall_pulse_o (fall_pulse)
    );

    assign any_edge = rise_det | fall_det;

    logic [CNT_W-1:0]   edge_cnt_q,     edge_cnt_d;
    logic               have_edge_q,    have_edge_d;
    logic [CNT_W-1:0]   high_time_q,    high_time_d;
    logic               high_valid_q,   high_valid_d;
    logic [CNT_W-1:0]   low_time_q,     low_time_d;
    logic               low_valid_q,    low_valid_d;
    logic [CNT_W-1:0]   half_period_q,  half_period_d;
    logic [CNT_W-1:0]   period_q,       period_d;
    logic               period_valid_q, period_valid_d;
    logic               timeout_q,      timeout_d;
    lock_state_e        state_q,        state_d;
    logic [MATCH_W-1:0] match_q,        match_d;
    logic               locked_q,       locked_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             hit_timeout;
    logic [CNT_W:0]   period_sum;
    logic [CNT_W-1:0] period_sat;
    logic [CNT_W-1:0] ref_time;
    logic             ref_valid;
    logic             cmp_valid;
    logic             cmp_ok;

    assign cnt_inc     = (edge_cnt_q >= TIMEOUT_C) ? TIMEOUT_C : edge_cnt_q + CNT_W'(1);
    assign hit_timeout = ~any_edge & (cnt_inc == TIMEOUT_C);

    // The edge being measured completes the low half, so it joins the stored high half.
    assign period_sum = {1'b0, high_time_q} + {1'b0, edge_cnt_q};
    assign period_sat = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];

    assign ref_time  = rise_det ? low_time_q  : high_time_q;
    assign ref_valid = rise_det ? low_valid_q : high_valid_q;
    assign cmp_valid = any_edge & have_edge_q & ref_valid;
    assign cmp_ok    = (abs_diff(edge_cnt_q, ref_time) <= LOCK_TOL_C);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the
        // branches below can leave a signal unassigned and infer a latch.
        edge_cnt_d     = cnt_inc;
        have_edge_d    = have_edge_q;
        high_time_d    = high_time_q;
        high_valid_d   = high_valid_q;
        low_time_d     = low_time_q;
        low_valid_d    = low_valid_q;
        half_period_d  = half_period_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        timeout_d      = timeout_q;

        if (any_edge) begin
            edge_cnt_d = CNT_W'(1);
            timeout_d  = 1'b0;
            if (!have_edge_q) begin
                have_edge_d = 1'b1;
            end else begin
                half_period_d = edge_cnt_q;
                if (fall_det) begin
                    high_time_d  = edge_cnt_q;
                    high_valid_d = 1'b1;
                end else begin
                    low_time_d  = edge_cnt_q;
                    low_valid_d = 1'b1;
                    if (high_valid_q) begin
                        period_d       = period_sat;
                        period_valid_d = 1'b1;
                    end
                end
            end
        end else if (hit_timeout) begin
            timeout_d      = 1'b1;
            have_edge_d    = 1'b0;
            high_valid_d   = 1'b0;
            low_valid_d    = 1'b0;
            period_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        match_d = match_q;

        if (hit_timeout) begin
            state_d = UNLOCKED;
            match_d = '0;
        end else if (cmp_valid) begin
            if (!cmp_ok) begin
                state_d = UNLOCKED;
                match_d = '0;
            end else begin
                unique case (state_q)
                    UNLOCKED: begin
                        match_d = MATCH_W'(1);
                        state_d = (match_d >= LOCK_COUNT_C) ? LOCKED : ACQUIRING;
                    end
                    ACQUIRING: begin
                        match_d = match_q + MATCH_W'(1);
                        state_d = (match_d >= LOCK_COUNT_C) ? LOCKED : ACQUIRING;
                    end
                    default: begin
                        state_d = LOCKED;
                    end
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            edge_cnt_q     <= '0;
            have_edge_q    <= 1'b0;
            high_time_q    <= '0;
            high_valid_q   <= 1'b0;
            low_time_q     <= '0;
            low_valid_q    <= 1'b0;
            half_period_q  <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            state_q        <= UNLOCKED;
            match_q        <= '0;
            locked_q       <= 1'b0;
        end else begin
            edge_cnt_q     <= edge_cnt_d;
            have_edge_q    <= have_edge_d;
            high_time_q    <= high_time_d;
            high_valid_q   <= high_valid_d;
            low_time_q     <= low_time_d;
            low_valid_q    <= low_valid_d;
            half_period_q  <= half_period_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            timeout_q      <= timeout_d;
            state_q        <= state_d;
            match_q        <= match_d;
            locked_q       <= locked_d;
        end
    end

`ifdef CLK_EDGE_METER_DUTY_CHECK_EN
    logic duty_err_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            duty_err_q <= 1'b0;
        end else if (hit_timeout) begin
            duty_err_q <= 1'b0;
        end else if (rise_det && have_edge_q && high_valid_q) begin
            duty_err_q <= (abs_diff(high_time_q, edge_cnt_q) > LOCK_TOL_C);
        end
    end

    assign duty_err = duty_err_q;
`else
    assign duty_err = 1'b0;
`endif

    assign half_period  = half_period_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Randomised and directed bench for clk_edge_meter against a time-difference reference model.
// Expects duty_err to track the model only when CLK_EDGE_METER_DUTY_CHECK_EN is defined.
module tb_clk_edge_meter;

    localparam int SS  = 2;
    localparam int CW  = 32;
    localparam int TO  = 100;
    localparam int TOL = 2;
    localparam int LC  = 4;
`ifdef CLK_EDGE_METER_DUTY_CHECK_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          div_clk_in = 1'b0;
    logic          rise_pulse, fall_pulse, period_valid, locked, timeout, duty_err;
    logic [CW-1:0] half_period, period;

    clk_edge_meter #(
        .SYNC_STAGES (SS),
        .CNT_W       (CW),
        .TIMEOUT     (TO),
        .LOCK_TOL    (TOL),
        .LOCK_COUNT  (LC)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .div_clk_in   (div_clk_in),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .half_period  (half_period),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout),
        .duty_err     (duty_err)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint absd(input longint a, input longint b);
        return (a >= b) ? a - b : b - a;
    endfunction

    // Reference model: edges are changes between consecutive post-reset input
    // samples, reported SS cycles after the later sample; measurements are
    // differences between report times.
    longint t, last_t;
    bit     samp_q[$];
    bit     m_have, m_hv, m_lv, m_pv, m_to, m_duty, m_rise, m_fall;
    longint m_ht, m_lt, m_half, m_per;
    int     streak;
    bit     model_ready = 1'b0;

    always @(posedge clk_in) begin : model
        longint m;
        longint refv;
        bit     ref_ok;
        cyc++;
        if (rst) begin
            t = 0; last_t = 1; samp_q.delete();
            m_have = 0; m_hv = 0; m_lv = 0; m_pv = 0; m_to = 0; m_duty = 0;
            m_rise = 0; m_fall = 0; m_ht = 0; m_lt = 0; m_half = 0; m_per = 0;
            streak = 0;
        end else begin
            t++;
            samp_q.push_back(div_clk_in);
            if (samp_q.size() > SS + 2) void'(samp_q.pop_front());
            m_rise = 0;
            m_fall = 0;
            if (samp_q.size() == SS + 2 && samp_q[0] != samp_q[1]) begin
                m_rise = samp_q[1];
                m_fall = !samp_q[1];
            end
            if (m_rise || m_fall) begin
                m_to = 0;
                if (!m_have) begin
                    m_have = 1;
                end else begin
                    m      = t - last_t;
                    ref_ok = m_rise ? m_lv : m_hv;
                    refv   = m_rise ? m_lt : m_ht;
                    if (ref_ok) streak = (absd(m, refv) <= TOL) ? streak + 1 : 0;
                    m_half = m;
                    if (m_fall) begin
                        m_ht = m; m_hv = 1;
                    end else begin
                        m_lt = m; m_lv = 1;
                        if (m_hv) begin
                            m_per = (m_ht + m > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_ht + m;
                            m_pv  = 1;
                            if (DUTY_EN) m_duty = (absd(m_ht, m) > TOL);
                        end
                    end
                end
                last_t = t;
            end else if (t - last_t + 1 >= TO) begin
                m_to = 1; m_have = 0; m_hv = 0; m_lv = 0; m_pv = 0; streak = 0; m_duty = 0;
            end
        end
        model_ready = 1'b1;
    end

    always @(negedge clk_in) begin : compare
        if (model_ready) begin
            check("rise_pulse",   rise_pulse,   m_rise);
            check("fall_pulse",   fall_pulse,   m_fall);
            check("half_period",  half_period,  m_half);
            check("period",       period,       m_per);
            check("period_valid", period_valid, m_pv);
            check("locked",       locked,       (streak >= LC));
            check("timeout",      timeout,      m_to);
            check("duty_err",     duty_err,     m_duty);
        end
    end

    // Strobe log, indexed by edge number since the last reset.
    int     ecount = 0;
    int     strobe_total = 0;
    int     last_strobe_cyc = 0;
    longint log_hp [1:32];
    longint log_per[1:32];
    bit     log_pv [1:32];
    bit     log_lk [1:32];

    always @(negedge clk_in) begin : strobe_log
        if (rst) begin
            ecount = 0;
        end else if (rise_pulse || fall_pulse) begin
            ecount++;
            strobe_total++;
            last_strobe_cyc = cyc;
            if (ecount <= 32) begin
                log_hp[ecount]  = half_period;
                log_per[ecount] = period;
                log_pv[ecount]  = period_valid;
                log_lk[ecount]  = locked;
            end
        end
    end

    longint snap_hp;
    bit     snap_pv, snap_lk, snap_to;

    task automatic hold(input int n, output int first);
        first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_in);
            if (first < 0 && (rise_pulse || fall_pulse)) begin
                first   = i;
                snap_hp = half_period;
                snap_pv = period_valid;
                snap_lk = locked;
                snap_to = timeout;
            end
        end
    endtask

    task automatic tog(input int n, output int first);
        div_clk_in = ~div_clk_in;
        hold(n, first);
    endtask

    initial begin : stim
        int f;
        int s;
        int to_cyc;
        int n0;
        int r;

        rst = 1'b1;
        div_clk_in = 1'b0;
        hold(3, f);
        check("rst_half_period",  half_period,  0);
        check("rst_period",       period,       0);
        check("rst_period_valid", period_valid, 0);
        check("rst_locked",       locked,       0);
        check("rst_timeout",      timeout,      0);
        check("rst_rise",         rise_pulse,   0);

        // Toggle every 2 cycles.
        rst = 1'b0;
        hold(6, f);
        for (int i = 0; i < 16; i++) tog(2, f);
        hold(10, f);
        check("p1_edges",     ecount,     16);
        check("p1_pv_edge2",  log_pv[2],  0);
        check("p1_pv_edge3",  log_pv[3],  1);
        check("p1_per_edge3", log_per[3], 4);
        check("p1_hp_edge3",  log_hp[3],  2);
        check("p1_lk_edge6",  log_lk[6],  0);
        check("p1_lk_edge7",  log_lk[7],  1);

        // Toggle every 5 cycles, measuring strobe latency.
        for (int i = 0; i < 13; i++) begin
            tog(5, f);
            check("p2_latency", f, SS + 1);
        end
        check("p2_half", half_period, 5);
        check("p2_period", period, 10);
        check("p2_locked", locked, 1);

        // Hold high until timeout.
        s = last_strobe_cyc;
        to_cyc = -1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk_in);
            if (timeout && to_cyc < 0) begin
                to_cyc = cyc;
                check("to_locked", locked, 0);
                check("to_pv", period_valid, 0);
            end
        end
        check("to_cycle", to_cyc - s, 99);
        tog(5, f);
        check("to_edge_seen", f, SS + 1);
        check("to_cleared", snap_to, 0);
        check("to_half_kept", snap_hp, 5);
        check("to_pv_after", snap_pv, 0);

        // Jitter 10..12, then a 15-cycle half.
        for (int i = 0; i < 16; i++) tog(int'($urandom_range(10, 12)), f);
        check("jit_locked", locked, 1);
        tog(15, f);
        check("jit_lock_held", snap_lk, 1);
        tog(12, f);
        check("jit_half15", snap_hp, 15);
        check("jit_unlock", snap_lk, 0);

        // Reset while locked with the input held high.
        for (int i = 0; i < 11; i++) tog(4, f);
        check("p5_locked", locked, 1);
        check("p5_input_high", div_clk_in, 1);
        rst = 1'b1;
        hold(3, f);
        rst = 1'b0;
        n0 = strobe_total;
        hold(12, f);
        check("p5_no_strobe", strobe_total - n0, 0);
        check("p5_half", half_period, 0);
        check("p5_period", period, 0);
        check("p5_locked0", locked, 0);
        check("p5_pv0", period_valid, 0);

        // High 3, low 9.
        for (int i = 0; i < 5; i++) begin
            tog(9, f);
            tog(3, f);
        end
        check("duty_period", period, 12);
        check("duty_half", half_period, 9);
        check("duty_err", duty_err, DUTY_EN);

        // Random toggling, long holds and reset pulses.
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                rst = 1'b1;
                hold(int'($urandom_range(1, 3)), f);
                rst = 1'b0;
            end else if (r < 9) begin
                tog(int'($urandom_range(100, 130)), f);
            end else begin
                tog(int'($urandom_range(1, 20)), f);
            end
        end
        hold(5, f);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
